mag_comp_iter: RTL and testbench

Parametrised, iterative magnitude comparator for WIDTH-bit operands with unsigned and two's-complement signed modes. It compares CHUNK bits per cycle, MSB chunk first, and terminates early at the first differing chunk. It trades latency for a narrow compare datapath and supersedes the fixed 4-bit combinational comparator wherever wide operands arrive through a start/done handshake.

---
 rtl/mag_comp_pkg.sv | 27 ++
 rtl/mag_comp_chunk.sv | 17 +
 rtl/mag_comp_iter.sv | 135 +++++++++++++
 tb/tb_mag_comp_iter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mag_comp_pkg.sv
// Shared types, result encoding and sizing helpers for the iterative magnitude comparator.
package mag_comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

  // Result vector ordering is {EQ, GT, LT}; exactly one bit set once a compare completes.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Number of chunks the operand is split into.
  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit so a single-chunk build still has a counter.
  function automatic int unsigned calc_idx_w(input int unsigned width, input int unsigned chunk);
    int unsigned n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mag_comp_chunk.sv
// Combinational CHUNK-bit unsigned compare of one operand slice.
module mag_comp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             chunk_eq_c,
  output logic             chunk_gt_c
);

  // Equality and greater-than of the current slice.
  always_comb begin
    chunk_eq_c = (a_i == b_i);
    chunk_gt_c = (a_i > b_i);
  end

endmodule

// File: rtl/mag_comp_iter.sv
// Iterative MSB-first magnitude comparator with early termination on the first differing chunk.
module mag_comp_iter
  import mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Reject parameter sets that cannot be split into whole chunks.
  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("mag_comp_iter: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_eq, chunk_gt;
  logic             last_chunk;

  // Select the chunk addressed by the index counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  mag_comp_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i        (a_chunk),
    .b_i        (b_chunk),
    .chunk_eq_c (chunk_eq),
    .chunk_gt_c (chunk_gt)
  );

  assign last_chunk = (idx_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave CMP on the first differing chunk or after the LSB chunk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CMP;
      CMP:     if (!chunk_eq || last_chunk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values; sign-bit flip maps signed order onto unsigned order.
  always_comb begin
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = A ^ (signed_mode ? SIGN_MASK : '0);
          b_d   = B ^ (signed_mode ? SIGN_MASK : '0);
          idx_d = IDX_TOP;
        end
      end
      CMP: begin
        if (!chunk_eq) begin
          res_d  = chunk_gt ? RES_GT : RES_LT;
          done_d = 1'b1;
        end else if (last_chunk) begin
          res_d  = RES_EQ;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= IDX_TOP;
      res_q  <= RES_NONE;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  // Operand latches need no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == CMP);
  assign done = done_q;
  assign EQ   = res_q[2];
  assign GT   = res_q[1];
  assign LT   = res_q[0];

endmodule

// File: tb/tb_mag_comp_iter.sv
// Directed bench for mag_comp_iter: 16/4 build for protocol cases, 8/8 build for single-cycle compares.
module tb_mag_comp_iter;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_EQ   = 3'b100;
  localparam logic [2:0] R_GT   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sm;
  logic [15:0] a, b;
  logic        busy, done, eq, gt, lt;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, eq8, gt8, lt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mag_comp_iter #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .A(a), .B(b),
    .busy(busy), .done(done), .EQ(eq), .GT(gt), .LT(lt)
  );

  mag_comp_iter #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .EQ(eq8), .GT(gt8), .LT(lt8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (edge 0).
  task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic smv);
    a = av; b = bv; sm = smv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, busy profile and result.
  task automatic wait_done16(input string tag, input int exp_lat, input logic [2:0] exp_res);
    int lat;
    int busy_cycles;
    lat = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_res"}, 32'({eq, gt, lt}), 32'(exp_res));
  endtask

  initial begin
    int dones;
    logic [2:0] exp8;

    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_res", 32'({eq, gt, lt}), 32'(R_NONE));
    check("reset_res8", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
    tick();

    // Equal operands walk all four chunks.
    start16(16'h1234, 16'h1234, 1'b0);
    check("t1_busy_start", 32'(busy), 32'd1);
    wait_done16("t1_eq", 4, R_EQ);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // MSB chunk decides; sign flip reverses the outcome.
    start16(16'h8000, 16'h7FFF, 1'b0);
    wait_done16("t2_uns", 1, R_GT);
    start16(16'h8000, 16'h7FFF, 1'b1);
    wait_done16("t2_sgn", 1, R_LT);

    // Second chunk decides; negative values compare equal-prefix down to the LSB chunk.
    start16(16'h1300, 16'h12FF, 1'b0);
    wait_done16("t3_uns", 2, R_GT);
    start16(16'hFFFF, 16'hFFFE, 1'b1);
    wait_done16("t3_sgn", 4, R_GT);

    // Start while busy is ignored; start on the done cycle is accepted.
    start16(16'h0001, 16'h0002, 1'b0);
    tick();
    a = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy_mid", 32'(busy), 32'd1);
    tick();
    check("t4_no_early_done", 32'(done), 32'd0);
    tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_res", 32'({eq, gt, lt}), 32'(R_LT));
    start16(16'h0000, 16'h0000, 1'b0);
    check("t4_b2b_busy", 32'(busy), 32'd1);
    check("t4_b2b_hold", 32'({eq, gt, lt}), 32'(R_LT));
    wait_done16("t4_b2b", 4, R_EQ);

    // Reset mid-compare aborts without a done pulse.
    start16(16'h0000, 16'h0000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_res", 32'({eq, gt, lt}), 32'(R_NONE));
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    start16(16'h00F0, 16'h0F00, 1'b0);
    wait_done16("t5_after", 2, R_LT);

    // Single-chunk build: fixed one-cycle latency across random operands.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom_range(0, 3) == 0 ? {24'd0, a8} : $urandom);
      sm8 = 1'(i % 2);
      if (sm8) exp8 = ($signed(a8) == $signed(b8)) ? R_EQ : ($signed(a8) > $signed(b8)) ? R_GT : R_LT;
      else     exp8 = (a8 == b8) ? R_EQ : (a8 > b8) ? R_GT : R_LT;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("t6_busy", 32'(busy8), 32'd1);
      tick();
      check("t6_done", 32'(done8), 32'd1);
      check("t6_res", 32'({eq8, gt8, lt8}), 32'(exp8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
